// File: rtl/hls_arith_pkg.sv
// Arithmetic helpers shared by the HLS multiplier pipeline: operand extension,
// product width and the supported pipeline depth.
package hls_arith_pkg;

    localparam int MAX_MUL_STAGE = 4;
    localparam int EXT_MAX_W     = 32;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w + 2;
    endfunction

    // Widen a width-bit operand held in the low bits of value; sign- or zero-fill above.
    function automatic logic [EXT_MAX_W-1:0] ext_operand(
        input logic [EXT_MAX_W-1:0] value,
        input int                   width,
        input logic                 signed_flag
    );
        logic [EXT_MAX_W-1:0] r_ext;
        logic                 w_fill;
        w_fill = signed_flag & value[width-1];
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i < width) begin
                r_ext[i] = value[i];
            end else begin
                r_ext[i] = w_fill;
            end
        end
        return r_ext;
    endfunction

endpackage

// File: rtl/hls_pipe_stage.sv
// One valid/ready register slice. The enclosing pipeline decides when the slice
// may load (empty or advancing); a loaded bubble clears valid but keeps the payload.
module hls_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slice register: payload only changes when a real item arrives
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/hls_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake, bubble
// collapse and optional accumulation at the output-stage load.
module hls_mul_pipe_hs
    import hls_arith_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 5,
    parameter int din1_WIDTH  = 3,
    parameter int dout_WIDTH  = 8,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 1,
    parameter int ACC_EN      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int PROD_W    = prod_width(din0_WIDTH, din1_WIDTH);
    localparam int MID_W     = PROD_W + 1;
    localparam int unused_id = ID;

    if (NUM_STAGE < 1 || NUM_STAGE > MAX_MUL_STAGE) begin : g_bad_stage
        $error("hls_mul_pipe_hs: NUM_STAGE=%0d outside 1..%0d", NUM_STAGE, MAX_MUL_STAGE);
    end

    logic signed [din0_WIDTH:0] w_a_ext;
    logic signed [din1_WIDTH:0] w_b_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic [NUM_STAGE:0]         w_vld;
    logic [NUM_STAGE:1]         w_ld;
    logic [MID_W-1:0]           w_mid [NUM_STAGE];
    logic [dout_WIDTH-1:0]      w_last_prod;
    logic [dout_WIDTH-1:0]      w_last_in;
    logic [dout_WIDTH-1:0]      w_dout;

    assign w_a_ext = (din0_WIDTH+1)'(ext_operand(32'(din0), din0_WIDTH, din0_SIGNED != 0));
    assign w_b_ext = (din1_WIDTH+1)'(ext_operand(32'(din1), din1_WIDTH, din1_SIGNED != 0));
    assign w_prod  = PROD_W'(w_a_ext) * PROD_W'(w_b_ext);

    assign w_vld[0] = in_valid;
    assign w_mid[0] = {in_first, w_prod};

    // Stage k may load when any stage from k to the output is empty, or the output drains
    for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_ld
        assign w_ld[k] = out_ready | ~(&w_vld[NUM_STAGE:k]);
    end

    for (genvar k = 1; k < NUM_STAGE; k++) begin : g_mid
        hls_pipe_stage #(.W(MID_W)) u_stage (
            .i_clk   (ap_clk),
            .i_rst_n (ap_rst_n),
            .i_load  (w_ld[k]),
            .i_valid (w_vld[k-1]),
            .i_data  (w_mid[k-1]),
            .o_valid (w_vld[k]),
            .o_data  (w_mid[k])
        );
    end

    // Output-stage payload; its register doubles as the accumulator, which only moves on a real load
    always_comb begin
        w_last_prod = dout_WIDTH'($signed(w_mid[NUM_STAGE-1][PROD_W-1:0]));
        w_last_in   = w_last_prod;
        if (ACC_EN != 0 && !w_mid[NUM_STAGE-1][PROD_W]) begin
            w_last_in = w_dout + w_last_prod;
        end else begin
            w_last_in = w_last_prod;
        end
    end

    hls_pipe_stage #(.W(dout_WIDTH)) u_out_stage (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_load  (w_ld[NUM_STAGE]),
        .i_valid (w_vld[NUM_STAGE-1]),
        .i_data  (w_last_in),
        .o_valid (w_vld[NUM_STAGE]),
        .o_data  (w_dout)
    );

    assign in_ready  = w_ld[1];
    assign out_valid = w_vld[NUM_STAGE];
    assign dout      = w_dout;

endmodule

// File: tb/tb_hls_mul_pipe_hs.sv
// Self-checking bench: four multiplier configurations checked every cycle
// against an in-order queue model, plus directed vectors with literal results.
`timescale 1ns/1ps
module tb_hls_mul_pipe_hs;

    localparam int NS [4] = '{2, 3, 1, 4};
    localparam int SA [4] = '{1, 0, 0, 1};
    localparam int SB [4] = '{1, 0, 0, 1};
    localparam int DW [4] = '{8, 8, 6, 8};
    localparam int AC [4] = '{0, 0, 0, 1};

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] in_valid  = 4'h0;
    logic [3:0] in_first  = 4'h0;
    logic [3:0] out_ready = 4'hF;
    logic [3:0] in_ready;
    logic [3:0] out_valid;
    logic [3:0] took;
    logic [4:0] din0 [4];
    logic [2:0] din1 [4];
    logic [7:0] dout0, dout1, dout3;
    logic [5:0] dout2;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int unsigned q_val [4][$];
    int          q_t   [4][$];
    int unsigned accv  [4];
    int unsigned got   [4][$];
    int unsigned eq [$];

    always #5 clk = ~clk;

    hls_mul_pipe_hs #(.ID(0), .NUM_STAGE(2), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(8),
                      .din0_SIGNED(1), .din1_SIGNED(1), .ACC_EN(0)) u_dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .din0(din0[0]), .din1(din1[0]), .in_first(in_first[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .dout(dout0));

    hls_mul_pipe_hs #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(8),
                      .din0_SIGNED(0), .din1_SIGNED(0), .ACC_EN(0)) u_dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .din0(din0[1]), .din1(din1[1]), .in_first(in_first[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .dout(dout1));

    hls_mul_pipe_hs #(.ID(2), .NUM_STAGE(1), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(6),
                      .din0_SIGNED(0), .din1_SIGNED(0), .ACC_EN(0)) u_dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .din0(din0[2]), .din1(din1[2]), .in_first(in_first[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .dout(dout2));

    hls_mul_pipe_hs #(.ID(3), .NUM_STAGE(4), .din0_WIDTH(5), .din1_WIDTH(3), .dout_WIDTH(8),
                      .din0_SIGNED(1), .din1_SIGNED(1), .ACC_EN(1)) u_dut3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .din0(din0[3]), .din1(din1[3]), .in_first(in_first[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .dout(dout3));

    function automatic int unsigned dout_of(input int d);
        case (d)
            0:       return {24'd0, dout0};
            1:       return {24'd0, dout1};
            2:       return {26'd0, dout2};
            default: return {24'd0, dout3};
        endcase
    endfunction

    // Reference arithmetic: integer product of the interpreted operands, wrapped to the output width
    function automatic int unsigned prod_of(input int d, input logic [4:0] a, input logic [2:0] b);
        int          ai, bi;
        int unsigned mask;
        ai   = (SA[d] != 0) ? int'($signed(a)) : int'(a);
        bi   = (SB[d] != 0) ? int'($signed(b)) : int'(b);
        mask = (32'd1 << DW[d]) - 32'd1;
        return 32'(ai * bi) & mask;
    endfunction

    task automatic chk(input string nm, input int d, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, d, act, exp);
        end
    endtask

    task automatic chk_got(input int d, input string nm);
        chk({nm, "_count"}, d, 32'(got[d].size()), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            chk(nm, d, (i < got[d].size()) ? got[d][i] : 32'hDEAD_BEEF, eq[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [4:0] a, input logic [2:0] b, input logic f);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        in_valid[d] = 1'b1; din0[d] = a; din1[d] = b; in_first[d] = f;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready[d];
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1 within 100 cycles", d);
        end
        in_valid[d] = 1'b0;
    endtask

    // Scoreboard: in-order items with accept cycle; front is due NUM_STAGE cycles after acceptance
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            logic        exp_rdy, exp_ov;
            int unsigned p, mask;
            if (!rst_n) begin
                q_val[d].delete();
                q_t[d].delete();
                accv[d] = 32'd0;
                chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
                chk("rst_dout", d, dout_of(d), 32'd0);
            end else begin
                mask    = (32'd1 << DW[d]) - 32'd1;
                exp_rdy = out_ready[d] || (q_val[d].size() < NS[d]);
                exp_ov  = (q_val[d].size() > 0) && (cyc >= q_t[d][0] + NS[d]);
                chk("in_ready", d, 32'(in_ready[d]), 32'(exp_rdy));
                chk("out_valid", d, 32'(out_valid[d]), 32'(exp_ov));
                if (exp_ov) chk("dout", d, dout_of(d), q_val[d][0]);
                if (exp_ov && out_ready[d]) begin
                    void'(q_val[d].pop_front());
                    void'(q_t[d].pop_front());
                end
                if (in_valid[d] && exp_rdy) begin
                    p = prod_of(d, din0[d], din1[d]);
                    if (AC[d] != 0) begin
                        accv[d] = ((in_first[d] ? 32'd0 : accv[d]) + p) & mask;
                        q_val[d].push_back(accv[d]);
                    end else begin
                        q_val[d].push_back(p);
                    end
                    q_t[d].push_back(cyc);
                end
            end
        end
        cyc++;
    end

    // Record every output transfer for the directed literal checks
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst_n && out_valid[d] && out_ready[d]) got[d].push_back(dout_of(d));
        end
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            din0[d] = 5'd0;
            din1[d] = 3'd0;
        end
        chk("model_signed", 0, prod_of(0, 5'h10, 3'h4), 32'h40);
        chk("model_uns8", 1, prod_of(1, 5'h1F, 3'h7), 32'hD9);
        chk("model_uns6", 2, prod_of(2, 5'h1F, 3'h7), 32'h19);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);

        // Signed products back to back
        got[0].delete();
        send(0, 5'h10, 3'h4, 1'b0);
        send(0, 5'h0F, 3'h4, 1'b0);
        send(0, 5'h10, 3'h3, 1'b0);
        idle(6);
        eq = '{32'h40, 32'hC4, 32'hD0};
        chk_got(0, "signed");

        // Unsigned, full width and wrapped width
        got[1].delete();
        got[2].delete();
        send(1, 5'h1F, 3'h7, 1'b0);
        send(2, 5'h1F, 3'h7, 1'b0);
        idle(6);
        eq = '{32'hD9};
        chk_got(1, "unsigned8");
        eq = '{32'h19};
        chk_got(2, "unsigned6");

        // Backpressure: two accepts fill the 2-stage pipe, then release
        got[0].delete();
        out_ready[0] = 1'b0;
        send(0, 5'h01, 3'h1, 1'b0);
        send(0, 5'h02, 3'h3, 1'b0);
        in_valid[0] = 1'b1; din0[0] = 5'h1F; din1[0] = 3'h2;
        idle(3);
        @(negedge clk);
        chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
        chk("bp_out_valid", 0, 32'(out_valid[0]), 32'd1);
        chk("bp_dout_hold", 0, 32'(dout0), 32'h01);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        send(0, 5'h1F, 3'h2, 1'b0);
        send(0, 5'h05, 3'h6, 1'b0);
        send(0, 5'h07, 3'h3, 1'b0);
        send(0, 5'h1D, 3'h5, 1'b0);
        idle(6);
        eq = '{32'h01, 32'h06, 32'hFE, 32'hF6, 32'h15, 32'h09};
        chk_got(0, "bp_order");

        // Accumulate: 3, +5, -2, restart with 4
        got[3].delete();
        send(3, 5'h03, 3'h1, 1'b1);
        send(3, 5'h05, 3'h1, 1'b0);
        send(3, 5'h1E, 3'h1, 1'b0);
        send(3, 5'h04, 3'h1, 1'b1);
        idle(8);
        eq = '{32'h03, 32'h08, 32'h06, 32'h04};
        chk_got(3, "acc");

        // Asynchronous reset with two items in flight
        got[0].delete();
        send(0, 5'h02, 3'h2, 1'b0);
        send(0, 5'h03, 3'h3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("async_out_valid", d, 32'(out_valid[d]), 32'd0);
            chk("async_dout", d, dout_of(d), 32'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);
        send(0, 5'h02, 3'h3, 1'b0);
        idle(5);
        eq = '{32'h06};
        chk_got(0, "post_reset");

        // Random valid/ready on all four depths
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) took[d] = in_valid[d] & in_ready[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (!in_valid[d] || took[d]) begin
                    in_valid[d] = ($urandom_range(0, 3) != 0);
                    din0[d]     = 5'($urandom);
                    din1[d]     = 3'($urandom);
                    in_first[d] = ($urandom_range(0, 3) == 0);
                end
                out_ready[d] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            if (took[d] || !(in_valid[d] && in_ready[d])) in_valid[d] = in_valid[d];
        end
        @(posedge clk);
        #1;
        in_valid  = 4'h0;
        out_ready = 4'hF;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_mul_pipe_hs.md
Name: hls_mul_pipe_hs

Overview:
- Parametrised, pipelined signed/unsigned integer multiplier for HLS-generated datapaths.
- Successor to the purely combinational fixed-width multiplier cores.
- Adds configurable pipeline depth, per-operand signedness, a valid/ready handshake with backpressure, and an optional accumulate mode.
- Sits between HLS dataflow stages wherever a multiply must close timing.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, register stages from input to output; legal range 1..4.
- din0_WIDTH, 5, width of operand A.
- din1_WIDTH, 3, width of operand B.
- dout_WIDTH, 8, width of the result.
- din0_SIGNED, 1, 1 = A is two's complement; 0 = A is unsigned.
- din1_SIGNED, 1, 1 = B is two's complement; 0 = B is unsigned.
- ACC_EN, 0, 1 = output is the running sum of products; 0 = output is the plain product.

Ports:
- ap_clk, in, 1, clock; all state on rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operands and first flag valid.
- in_ready, out, 1, block accepts an input this cycle.
- din0, in, din0_WIDTH, operand A.
- din1, in, din1_WIDTH, operand B.
- in_first, in, 1, used only when ACC_EN=1: restart the accumulator with this product.
- out_valid, out, 1, dout valid.
- out_ready, in, 1, consumer accepts dout.
- dout, out, dout_WIDTH, product or accumulated sum.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All stage valid bits clear; out_valid=0; dout=0; accumulator=0.
  - in_ready=1 from the first cycle after reset release.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Arithmetic:
  - Each operand is extended by one bit, sign- or zero-extended per din*_SIGNED.
  - Full product is (din0_WIDTH+din1_WIDTH+2) bits; dout takes the low dout_WIDTH bits (wrap, no saturation).
  - ACC_EN=1: acc_next = (in_first ? 0 : acc) + product, computed modulo 2^dout_WIDTH.
- Latency:
  - With no stall, an input accepted in cycle N appears with out_valid=1 in cycle N+NUM_STAGE.
  - Throughput is one result per cycle.
- Pipeline control:
  - Stages 1..NUM_STAGE each hold a valid bit plus payload; stage NUM_STAGE drives out_valid/dout.
  - Stage k loads from k-1 when stage k is empty or stage k is advancing (bubble collapse).
  - Output stage advances when out_ready=1 or out_valid=0.
  - in_ready = !v1 || stage1 advancing. It is combinational from out_ready through the chain; no registered skid.
- Backpressure:
  - While out_valid=1 and out_ready=0, dout and out_valid hold stable.
  - Stages fill until stage 1 is occupied, then in_ready=0.
  - The pipeline holds at most NUM_STAGE items; none is dropped or duplicated.
- Accumulation:
  - Performed at the output-stage load. The accumulator updates only on load into the last stage, never on stall.
  - Multiplier partial products are pipelined in the earlier stages.
  - NUM_STAGE=1: multiply and accumulate are in one stage.
  - ACC_EN=0: in_first is ignored.
- Simultaneous events:
  - Output transfer and last-stage load in the same cycle: the new item replaces the old one; out_valid stays 1.
  - Full pipeline with out_ready=1 and in_valid=1: one in, one out, in_ready stays 1.
- Reset mid-operation: all in-flight items are discarded, the accumulator is cleared, and out_valid drops immediately (async).
- Illegal NUM_STAGE: elaboration error via generate-time check.

Decomposition:
- Shared package hls_arith_pkg holds:
  - function ext_operand(value, width, signed_flag) returning the extended operand;
  - localparam computation PROD_W = din0_WIDTH+din1_WIDTH+2;
  - constant MAX_MUL_STAGE = 4.
- One sub-module, hls_pipe_stage: a valid/ready register slice with bubble collapse. It is instantiated NUM_STAGE times via generate; the arithmetic is placed between slices.

Test Plan:
- Signed, NUM_STAGE=2, out_ready=1: din0=-16, din1=-4 -> dout=0x40 two cycles later; din0=15, din1=-4 -> 0xC4; din0=-16, din1=3 -> 0xD0; back-to-back, one result per cycle.
- din0_SIGNED=0, din1_SIGNED=0: din0=31, din1=7 -> 217 (0xD9); din0=31, din1=7 with dout_WIDTH=6 -> 0x19 (wrap).
- Backpressure: stream 6 items with out_ready=0 -> in_ready falls after 2 accepts; dout holds the first result. Release out_ready -> all 6 results emerge in order, none lost.
- ACC_EN=1: products 3, 5, -2 with in_first=1,0,0 -> dout 3, 8, 6. Next item with in_first=1 and product 4 -> dout 4.
- Reset pulse while 2 items are in flight -> out_valid=0 asynchronously, dout=0. After release, a new input 2*3 -> 6 with no stale output.
- NUM_STAGE sweep 1..4: latency measured equals NUM_STAGE; random valid/ready against a reference model matches bit-exactly over 10k transactions.
